// File: rtl/instruction_q_mw_pkg.sv
// Shared types and default sizes for the front-end instruction queue.
// The queue entry carries the decoded instruction word, its PC and the
// fetch-time branch prediction bit.
package rv32i_types;

    localparam int SS_FETCH_WIDTH    = 2;
    localparam int SS_DISPATCH_WIDTH = 2;
    localparam int IQ_DEPTH          = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        branch_pred;
    } iqueue_entry_t;

endpackage

// File: rtl/instruction_q_mw_if.sv
// Handshake bundle between fetch/decode (master) and the instruction
// queue (slave). Dispatch-side outputs travel in the same bundle.
interface instruction_q_mw_if
    import rv32i_types::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int ENQ_WIDTH = SS_FETCH_WIDTH,
    parameter int DEQ_WIDTH = SS_DISPATCH_WIDTH
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int TAKE_W = $clog2(DEQ_WIDTH + 1);

    logic                           flush;
    iqueue_entry_t [ENQ_WIDTH-1:0]  enq_inst;
    logic [ENQ_WIDTH-1:0]           enq_valid;
    logic                           enq_ready;
    iqueue_entry_t [DEQ_WIDTH-1:0]  deq_inst;
    logic [DEQ_WIDTH-1:0]           deq_valid;
    logic [TAKE_W-1:0]              deq_take;
    logic [CNT_W-1:0]               count;
    logic                           empty;
    logic                           full;

    modport master (
        output flush, enq_inst, enq_valid, deq_take,
        input  enq_ready, deq_inst, deq_valid, count, empty, full
    );

    modport slave (
        input  flush, enq_inst, enq_valid, deq_take,
        output enq_ready, deq_inst, deq_valid, count, empty, full
    );

endinterface

// File: rtl/iq_wrap_add.sv
// Circular-buffer pointer adder: (ptr + inc) wrapped into [0, DEPTH).
// Both operands are below DEPTH, so one conditional subtract suffices and
// non-power-of-two depths need no modulo.
module iq_wrap_add #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [PTR_W:0]   inc_i,
    output logic [PTR_W-1:0] sum_o
);
    localparam logic [PTR_W:0] DEPTH_W = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0] raw;

    // Add, then fold back once if the sum ran past the last slot.
    always_comb begin
        raw = {1'b0, ptr_i} + inc_i;
        if (raw >= DEPTH_W) begin
            raw = raw - DEPTH_W;
        end
        sum_o = raw[PTR_W-1:0];
    end

endmodule

// File: rtl/instruction_q_mw.sv
// Multi-width in-order instruction queue between decode and dispatch.
// Up to ENQ_WIDTH entries enter and DEQ_WIDTH leave per cycle; output is
// first-word-fall-through; flush empties the queue on the next edge.
// Optional macro IQ_BYPASS_EN: when empty, an enqueuing group is shown on
// the dequeue lanes in the same cycle and may be consumed immediately.
module instruction_q_mw
    import rv32i_types::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int ENQ_WIDTH = SS_FETCH_WIDTH,
    parameter int DEQ_WIDTH = SS_DISPATCH_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    instruction_q_mw_if.slave q
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NW    = $clog2(ENQ_WIDTH + 1);
    localparam int MW    = $clog2(DEQ_WIDTH + 1);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - ENQ_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    logic [PTR_W-1:0]              head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]              count_q, count_d;
    iqueue_entry_t                 mem_q [DEPTH];
    logic [NW-1:0]                 n;
    logic                          enq_fire;
    logic                          bypass;
    logic [ENQ_WIDTH-1:0]          wr_en;
    logic [PTR_W-1:0]              waddr [ENQ_WIDTH];
    logic [PTR_W-1:0]              raddr [DEQ_WIDTH];
    logic [PTR_W-1:0]              head_adv, tail_adv;
    iqueue_entry_t [DEQ_WIDTH-1:0] deq_inst_c;
    logic [DEQ_WIDTH-1:0]          deq_valid_c;
    logic [MW-1:0]                 vld_cnt;
    logic [ENQ_WIDTH-1:0]          enq_v_inc;

    // Readiness only looks at the registered occupancy; no dequeue credit.
    assign q.enq_ready = (count_q <= READY_MAX);
    assign q.count     = count_q;
    assign q.empty     = (count_q == '0);
    assign q.full      = (count_q == DEPTH_C);
    assign q.deq_inst  = deq_inst_c;
    assign q.deq_valid = deq_valid_c;
    assign enq_fire    = q.enq_ready && q.enq_valid[0] && !q.flush;

`ifdef IQ_BYPASS_EN
    assign bypass = enq_fire && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    for (genvar k = 0; k < ENQ_WIDTH; k++) begin : g_waddr
        iq_wrap_add #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wadd (
            .ptr_i(tail_q), .inc_i(SUM_W'(k)), .sum_o(waddr[k])
        );
    end

    for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_raddr
        iq_wrap_add #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_radd (
            .ptr_i(head_q), .inc_i(SUM_W'(i)), .sum_o(raddr[i])
        );
    end

    iq_wrap_add #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_add (
        .ptr_i(head_q), .inc_i(SUM_W'(q.deq_take)), .sum_o(head_adv)
    );

    iq_wrap_add #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_add (
        .ptr_i(tail_q), .inc_i(SUM_W'(n)), .sum_o(tail_adv)
    );

    // Group size; valid lanes are contiguous from lane 0.
    always_comb begin
        n = '0;
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (q.enq_valid[k]) n = n + NW'(1);
        end
    end

    // Lane k lands at tail+k; lanes consumed through the bypass never land.
    // Head then moves past them, so the survivors sit at the new head.
    always_comb begin
        wr_en = '0;
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            wr_en[k] = enq_fire && q.enq_valid[k];
            if (bypass && (k < int'(q.deq_take))) wr_en[k] = 1'b0;
        end
    end

    // Pointer and occupancy update; flush overrides any same-cycle traffic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (q.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_adv;
            if (enq_fire) tail_d = tail_adv;
            count_d = count_q + (enq_fire ? CNT_W'(n) : '0) - CNT_W'(q.deq_take);
        end
    end

    // Control state; storage below is deliberately left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage write port, one slot per enqueuing lane.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (wr_en[k]) mem_q[waddr[k]] <= q.enq_inst[k];
        end
    end

`ifdef IQ_BYPASS_EN
    localparam int BYP_N = (ENQ_WIDTH < DEQ_WIDTH) ? ENQ_WIDTH : DEQ_WIDTH;
    iqueue_entry_t [DEQ_WIDTH-1:0] byp_inst;
    logic [DEQ_WIDTH-1:0]          byp_vld;

    // Incoming group re-laned onto the dequeue width, zero-padded.
    always_comb begin
        byp_inst = '0;
        byp_vld  = '0;
        for (int i = 0; i < BYP_N; i++) begin
            byp_inst[i]       = q.enq_inst[i];
            byp_inst[i].valid = q.enq_valid[i];
            byp_vld[i]        = q.enq_valid[i];
        end
    end
`endif

    // First-word-fall-through read lanes with valid masked by occupancy.
    always_comb begin
        deq_inst_c  = '0;
        deq_valid_c = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            deq_valid_c[i]      = (count_q > CNT_W'(i));
            deq_inst_c[i]       = mem_q[raddr[i]];
            deq_inst_c[i].valid = mem_q[raddr[i]].valid & deq_valid_c[i];
        end
`ifdef IQ_BYPASS_EN
        if (bypass) begin
            deq_inst_c  = byp_inst;
            deq_valid_c = byp_vld;
        end
`endif
    end

    // Number of dequeue lanes currently offered.
    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            if (deq_valid_c[i]) vld_cnt = vld_cnt + MW'(1);
        end
    end

    assign enq_v_inc = q.enq_valid + ENQ_WIDTH'(1);

    a_enq_contig: assert property (@(posedge clk) disable iff (!rst_n)
        ((q.enq_valid & enq_v_inc) == '0));
    a_deq_take: assert property (@(posedge clk) disable iff (!rst_n)
        (q.deq_take <= vld_cnt));
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        (count_q <= DEPTH_C));

endmodule

// File: tb/tb_instruction_q_mw.sv
// Directed bench for instruction_q_mw: an 8-deep and a 6-deep instance
// share clock and reset; expectations are hand-derived entry ids.
module tb_instruction_q_mw;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;

    instruction_q_mw_if #(.DEPTH(8), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) if8 ();
    instruction_q_mw_if #(.DEPTH(6), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) if6 ();

    instruction_q_mw #(.DEPTH(8), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) u_q8 (
        .clk(clk), .rst_n(rst_n), .q(if8)
    );
    instruction_q_mw #(.DEPTH(6), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) u_q6 (
        .clk(clk), .rst_n(rst_n), .q(if6)
    );

    always #5 clk = ~clk;

    function automatic iqueue_entry_t mk(input int id);
        iqueue_entry_t e;
        e.valid       = 1'b1;
        e.inst        = 32'h0bad_0000 + id;
        e.pc          = 32'h0000_1000 + id * 4;
        e.branch_pred = id[0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [1:0] v, input int id0, input int id1, input int take);
        if8.enq_valid   = v;
        if8.enq_inst[0] = mk(id0);
        if8.enq_inst[1] = mk(id1);
        if8.deq_take    = 2'(take);
    endtask

    task automatic drive6(input logic [1:0] v, input int id0, input int id1, input int take);
        if6.enq_valid   = v;
        if6.enq_inst[0] = mk(id0);
        if6.enq_inst[1] = mk(id1);
        if6.deq_take    = 2'(take);
    endtask

    initial begin
        int rd;
        int wr;
        rst_n     = 1'b0;
        if8.flush = 1'b0;
        if6.flush = 1'b0;
        drive8(2'b00, 0, 0, 0);
        drive6(2'b00, 0, 0, 0);
        #3;
        chk("rst_count", if8.count, 0);
        chk("rst_empty", if8.empty, 1);
        chk("rst_full", if8.full, 0);
        chk("rst_ready", if8.enq_ready, 1);
        chk("rst_dvalid", if8.deq_valid, 0);
        chk("rst_count6", if6.count, 0);
        #4 rst_n = 1'b1;
        step();

        // Fill 8 entries two at a time.
        for (int c = 0; c < 4; c++) begin
            drive8(2'b11, 2 * c, 2 * c + 1, 0);
            step();
            chk("fill_count", if8.count, 2 * (c + 1));
            chk("fill_ready", if8.enq_ready, (c < 3) ? 1 : 0);
        end
        chk("fill_full", if8.full, 1);
        chk("fill_dvalid", if8.deq_valid, 2'b11);
        chk("fill_lane0", if8.deq_inst[0], mk(0));
        chk("fill_lane1", if8.deq_inst[1], mk(1));
        // Group offered while not ready is ignored.
        drive8(2'b11, 90, 91, 0);
        step();
        chk("nordy_count", if8.count, 8);
        chk("nordy_lane0", if8.deq_inst[0], mk(0));
        // Drain in order.
        drive8(2'b00, 0, 0, 2);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("drain_lane0", if8.deq_inst[0], mk(2 * c));
            chk("drain_lane1", if8.deq_inst[1], mk(2 * c + 1));
            step();
            chk("drain_count", if8.count, 6 - 2 * c);
        end
        drive8(2'b00, 0, 0, 0);
        #1;
        chk("drain_empty", if8.empty, 1);
        chk("drain_dvalid", if8.deq_valid, 0);

        // Partial enqueue alongside a two-wide dequeue.
        drive8(2'b11, 10, 11, 0);
        step();
        drive8(2'b01, 12, 0, 0);
        step();
        chk("part_count3", if8.count, 3);
        drive8(2'b01, 13, 0, 2);
        #1;
        chk("part_pre0", if8.deq_inst[0], mk(10));
        chk("part_pre1", if8.deq_inst[1], mk(11));
        step();
        drive8(2'b00, 0, 0, 0);
        #1;
        chk("part_count2", if8.count, 2);
        chk("part_lane0", if8.deq_inst[0], mk(12));
        chk("part_lane1", if8.deq_inst[1], mk(13));
        chk("part_dvalid", if8.deq_valid, 2'b11);
        drive8(2'b00, 0, 0, 2);
        step();
        drive8(2'b00, 0, 0, 0);
        #1;
        chk("part_empty", if8.empty, 1);

        // Same-cycle visibility of an enqueue into an empty queue.
`ifdef IQ_BYPASS_EN
        drive8(2'b11, 20, 21, 1);
        #1;
        chk("byp_dvalid", if8.deq_valid, 2'b11);
        chk("byp_lane0", if8.deq_inst[0], mk(20));
        step();
        drive8(2'b00, 0, 0, 0);
        #1;
        chk("byp_count", if8.count, 1);
        chk("byp_next0", if8.deq_inst[0], mk(21));
        drive8(2'b00, 0, 0, 1);
        step();
`else
        drive8(2'b11, 20, 21, 0);
        #1;
        chk("byp_dvalid", if8.deq_valid, 0);
        step();
        drive8(2'b00, 0, 0, 0);
        #1;
        chk("byp_count", if8.count, 2);
        chk("byp_next0", if8.deq_inst[0], mk(20));
        drive8(2'b00, 0, 0, 2);
        step();
`endif
        drive8(2'b00, 0, 0, 0);
        #1;
        chk("byp_empty", if8.empty, 1);

        // Flush wins over simultaneous enqueue and dequeue.
        drive8(2'b11, 30, 31, 0);
        step();
        drive8(2'b11, 32, 33, 0);
        step();
        drive8(2'b01, 34, 0, 0);
        step();
        chk("fl_count5", if8.count, 5);
        if8.flush = 1'b1;
        drive8(2'b11, 35, 36, 1);
        step();
        if8.flush = 1'b0;
        drive8(2'b00, 0, 0, 0);
        #1;
        chk("fl_count", if8.count, 0);
        chk("fl_empty", if8.empty, 1);
        chk("fl_dvalid", if8.deq_valid, 0);
        chk("fl_ready", if8.enq_ready, 1);
        drive8(2'b11, 40, 41, 0);
        step();
        drive8(2'b00, 0, 0, 0);
        #1;
        chk("fl_refill_count", if8.count, 2);
        chk("fl_refill_lane0", if8.deq_inst[0], mk(40));
        drive8(2'b00, 0, 0, 2);
        step();

        // Asynchronous reset between edges.
        drive8(2'b11, 50, 51, 0);
        step();
        drive8(2'b11, 52, 53, 0);
        step();
        drive8(2'b00, 0, 0, 0);
        chk("ar_count4", if8.count, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_count", if8.count, 0);
        chk("ar_dvalid", if8.deq_valid, 0);
        chk("ar_empty", if8.empty, 1);
        #2 rst_n = 1'b1;
        step();

        // Non-power-of-two depth: 2-in/2-out streaming across the wrap.
        drive6(2'b11, 100, 101, 0);
        step();
        rd = 100;
        wr = 102;
        for (int c = 0; c < 10; c++) begin
            drive6(2'b11, wr, wr + 1, 2);
            #1;
            chk("wrap_lane0", if6.deq_inst[0], mk(rd));
            chk("wrap_lane1", if6.deq_inst[1], mk(rd + 1));
            step();
            chk("wrap_count", if6.count, 2);
            rd += 2;
            wr += 2;
        end
        drive6(2'b00, 0, 0, 0);
        #1;
        chk("wrap_tail0", if6.deq_inst[0], mk(rd));
        drive6(2'b00, 0, 0, 2);
        step();
        drive6(2'b00, 0, 0, 0);
        #1;
        chk("wrap_empty", if6.empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_q_mw.md
Name: instruction_q_mw

Overview:
- Parametrised multi-width successor of the in-order instruction queue.
- Sits between fetch/decode and rename/dispatch.
- Buffers up to DEPTH single-instruction entries in a circular array.
- Each cycle: accepts 0..ENQ_WIDTH instructions and releases 0..DEQ_WIDTH instructions, both variable count, with ready/valid handshakes.
- First-word-fall-through output; whole-queue flush on branch mispredict.

Parameters:
- DEPTH, 8: number of single-instruction entries; any integer >= max(ENQ_WIDTH, DEQ_WIDTH), not required to be a power of two.
- ENQ_WIDTH, SS_FETCH_WIDTH (2): maximum instructions enqueued per cycle.
- DEQ_WIDTH, SS_DISPATCH_WIDTH (2): maximum instructions dequeued per cycle.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  branch mispredict; empties the queue.
- enq_inst  in  ENQ_WIDTH x iqueue_entry_t  incoming instructions, lane 0 oldest.
- enq_valid  in  ENQ_WIDTH  per-lane valid; must be contiguous from lane 0.
- enq_ready  out  1  queue can accept a full ENQ_WIDTH group this cycle.
- deq_inst  out  DEQ_WIDTH x iqueue_entry_t  oldest entries, lane 0 oldest.
- deq_valid  out  DEQ_WIDTH  lane i valid iff count > i.
- deq_take  in  $clog2(DEQ_WIDTH+1)  number of lanes consumed this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async assert, rst_n=0):
  - head, tail and count cleared to 0; empty=1, full=0, enq_ready=1, deq_valid=0.
  - Storage data is not reset.
- enq_ready = (DEPTH - count) >= ENQ_WIDTH, computed from the registered count only; a same-cycle dequeue is not credited.
- Enqueue fires when enq_ready && enq_valid[0] && !flush:
  - n = popcount(enq_valid).
  - Lane k is written to slot (tail + k) wrapped; tail advances by n.
  - enq_valid with enq_ready=0 is ignored; upstream holds its group.
- Dequeue (no handshake beyond deq_take):
  - deq_inst[i] = storage[(head + i) wrapped], combinational.
  - deq_inst[i].valid is forced to 0 when count <= i.
  - deq_take = m advances head by m.
  - m > popcount(deq_valid) is illegal.
- Occupancy: count_next = count + n - m; enqueue and dequeue in the same cycle are legal at any occupancy.
- Wrap-around: pointers are $clog2(DEPTH) bits; ptr + k >= DEPTH subtracts DEPTH. No % operator, so non-power-of-two DEPTH works.
- Latency: an entry written at edge t is visible on deq_* after edge t (one cycle minimum, unless the optional bypass applies).
- Flush:
  - Synchronous; has priority over enqueue and dequeue in the same cycle.
  - Next cycle head=tail=count=0; any same-cycle enq/deq is discarded.
- Reset mid-operation: immediate clear regardless of flush, enq or deq.
- Assertions (simulation only):
  - non-contiguous enq_valid;
  - deq_take > popcount(deq_valid);
  - count > DEPTH.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined:
  - When count==0 and an enqueue fires without flush, deq_inst/deq_valid show enq_inst/enq_valid in the same cycle (lane i from enq lane i).
  - deq_take=m consumes m of these; only the remaining n-m are written, starting at tail.
  - head and tail both advance by m, tail by a further n-m.
- Undefined: no combinational path from enq_* to deq_*; minimum latency is one cycle.

Decomposition:
- Package rv32i_types (existing) holds:
  - iqueue_entry_t (valid, inst, pc, branch_pred);
  - SS_FETCH_WIDTH, SS_DISPATCH_WIDTH;
  - IQ_DEPTH default.
- One sub-module, iq_wrap_add:
  - parametrised by DEPTH;
  - computes (ptr + inc) with a single conditional subtract;
  - used for head, tail and per-lane read/write addresses.

Test Plan:
- Reset then fill: DEPTH=8, widths 2; four cycles of enq_valid=2'b11, deq_take=0 -> count 0,2,4,6,8; enq_ready drops once count=8 (2 free slots < 2 is never reached before 8), full=1.
- Partial enqueue and dequeue: count=3 with A,B,C queued; enq_valid=2'b01 (D), deq_take=2 -> next count=2, deq_inst lane0=C, lane1=D.
- Wrap with non-power-of-two DEPTH=6: stream 2-in/2-out for 10 cycles -> order preserved, tail indices wrap 4->0, count stays 2.
- Flush during simultaneous enq/deq: count=5, flush=1, enq_valid=2'b11, deq_take=1 -> next cycle count=0, empty=1, deq_valid=0.
- Async reset mid-stream: rst_n low between edges at count=4 -> count=0 and deq_valid=0 immediately, before the next edge.
- IQ_BYPASS_EN: empty queue, enq_valid=2'b11 (X,Y), deq_take=1 -> same cycle deq lane0=X; next cycle count=1, lane0=Y. Without the macro: deq_valid=0 in that cycle and count=2 next cycle.
